dispatch_throttle: RTL and testbench

- Dispatch-width controller for the N-wide rename/dispatch stage.
- Each cycle it decides how many fetched instructions dispatch (num_dispatched), limited by ROB slots, RS slots, free physical registers and free branch-stack entries.
- Owns a recovery FSM that blocks dispatch for a fixed window after a branch-stack restore.
- Keeps registered stall diagnostics for perf counters and debug.

---
 rtl/dispatch_pkg.sv | 25 ++
 rtl/dispatch_throttle_prefix_limit.sv | 30 +++
 rtl/dispatch_throttle.sv | 172 +++++++++++++++++
 tb/tb_dispatch_throttle.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
// dispatch_pkg : shared widths, FSM state and stall-reason types.  Rev 1.0
// ============================================================================
package dispatch_pkg;

  localparam int N               = 3;
  localparam int NUM_SCALAR_BITS = 2;
  localparam int B_MASK_WIDTH    = 4;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } DISPATCH_STATE;

  typedef struct packed {
    logic recover;
    logic branch;
    logic regs;
    logic rs;
    logic rob;
  } STALL_REASON;

endpackage
`default_nettype wire

// File: rtl/dispatch_throttle_prefix_limit.sv
`default_nettype none
// ============================================================================
// prefix_limit : ok_o[k] = popcount(bits_i[k:0]) <= limit_i.  Rev 1.0
// ============================================================================
module prefix_limit #(
  parameter int N       = 3,
  parameter int LIMIT_W = 2
) (
  input  logic [N-1:0]       bits_i,
  input  logic [LIMIT_W-1:0] limit_i,
  output logic [N-1:0]       ok_o
);
  import dispatch_pkg::*;

  localparam int PC_W = $clog2(N + 1);
  localparam int CW   = (PC_W > LIMIT_W) ? PC_W : LIMIT_W;

  logic [CW-1:0] run_cnt;

  always_comb begin
    run_cnt = '0;
    ok_o    = '0;
    for (int k = 0; k < N; k++) begin
      run_cnt = run_cnt + CW'(bits_i[k]);
      ok_o[k] = (run_cnt <= CW'(limit_i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/dispatch_throttle.sv
`default_nettype none
// ============================================================================
// dispatch_throttle : dispatch-width limiter with post-restore recovery FSM
// and registered stall diagnostics.  Rev 1.0
// ============================================================================
module dispatch_throttle #(
  parameter int N               = dispatch_pkg::N,
  parameter int NUM_SCALAR_BITS = dispatch_pkg::NUM_SCALAR_BITS,
  parameter int B_MASK_WIDTH    = dispatch_pkg::B_MASK_WIDTH,
  parameter int BS_CNT_BITS     = 3,
  parameter int RECOVER_CYCLES  = 1,
  parameter int STALL_CNT_W     = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SCALAR_BITS-1:0] instructions_valid,
  input  logic [N-1:0]               inst_has_dest,
  input  logic [N-1:0]               inst_is_branch,
  input  logic [NUM_SCALAR_BITS-1:0] rob_spots,
  input  logic [NUM_SCALAR_BITS-1:0] rs_spots,
  input  logic [NUM_SCALAR_BITS-1:0] num_regs_available,
  input  logic [BS_CNT_BITS-1:0]     bs_free,
  input  logic                       restore_valid,
  output logic [NUM_SCALAR_BITS-1:0] num_dispatched,
  output logic                       dispatch_stall,
  output logic                       recovering,
  output logic [4:0]                 stall_reason,
  output logic [STALL_CNT_W-1:0]     stall_cycles
);
  import dispatch_pkg::*;

  localparam int  CNT_W       = (RECOVER_CYCLES > 2) ? $clog2(RECOVER_CYCLES) : 1;
  localparam bit  HAS_RECOVER = (RECOVER_CYCLES > 0);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'((RECOVER_CYCLES > 0) ? RECOVER_CYCLES - 1 : 0);

  logic [NUM_SCALAR_BITS-1:0] valid_s, rob_s, rs_s, regs_s;
  logic [BS_CNT_BITS-1:0]     bs_s;
  logic [N-1:0]               valid_mask, dest_ok, br_ok;
  logic [NUM_SCALAR_BITS-1:0] raw_cnt;
  logic                       chain, gate;

  DISPATCH_STATE              state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  STALL_REASON                reason_q, reason_d;
  logic [STALL_CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  // Scalar counts can only exceed N when their encoding has headroom above N.
  if (((1 << NUM_SCALAR_BITS) - 1) > N) begin : g_sat
    assign valid_s = (instructions_valid > NUM_SCALAR_BITS'(N)) ? NUM_SCALAR_BITS'(N) : instructions_valid;
    assign rob_s   = (rob_spots > NUM_SCALAR_BITS'(N)) ? NUM_SCALAR_BITS'(N) : rob_spots;
    assign rs_s    = (rs_spots > NUM_SCALAR_BITS'(N)) ? NUM_SCALAR_BITS'(N) : rs_spots;
    assign regs_s  = (num_regs_available > NUM_SCALAR_BITS'(N)) ? NUM_SCALAR_BITS'(N) : num_regs_available;
  end else begin : g_nosat
    assign valid_s = instructions_valid;
    assign rob_s   = rob_spots;
    assign rs_s    = rs_spots;
    assign regs_s  = num_regs_available;
  end

  if (((1 << BS_CNT_BITS) - 1) > B_MASK_WIDTH) begin : g_bs_sat
    assign bs_s = (bs_free > BS_CNT_BITS'(B_MASK_WIDTH)) ? BS_CNT_BITS'(B_MASK_WIDTH) : bs_free;
  end else begin : g_bs_nosat
    assign bs_s = bs_free;
  end

  always_comb begin
    valid_mask = '0;
    for (int k = 0; k < N; k++) begin
      valid_mask[k] = (NUM_SCALAR_BITS'(k) < valid_s);
    end
  end

  // Slot bits beyond the valid range are masked so they never reach the prefix sums.
  prefix_limit #(
    .N       (N),
    .LIMIT_W (NUM_SCALAR_BITS)
  ) u_dest_limit (
    .bits_i  (inst_has_dest & valid_mask),
    .limit_i (regs_s),
    .ok_o    (dest_ok)
  );

  prefix_limit #(
    .N       (N),
    .LIMIT_W (BS_CNT_BITS)
  ) u_branch_limit (
    .bits_i  (inst_is_branch & valid_mask),
    .limit_i (bs_s),
    .ok_o    (br_ok)
  );

  always_comb begin
    chain   = 1'b1;
    raw_cnt = '0;
    for (int k = 0; k < N; k++) begin
      chain = chain & valid_mask[k]
                    & (NUM_SCALAR_BITS'(k) < rob_s)
                    & (NUM_SCALAR_BITS'(k) < rs_s)
                    & dest_ok[k] & br_ok[k];
      raw_cnt = raw_cnt + NUM_SCALAR_BITS'(chain);
    end
  end

  assign gate           = (state_q == RECOVER) | restore_valid;
  assign num_dispatched = gate ? '0 : raw_cnt;
  assign dispatch_stall = (num_dispatched < valid_s);

  // Reasons describe the first blocked slot, which is slot num_dispatched.
  always_comb begin
    reason_d = '0;
    if (dispatch_stall) begin
      reason_d.recover = gate;
      reason_d.rob     = (num_dispatched >= rob_s);
      reason_d.rs      = (num_dispatched >= rs_s);
      for (int k = 0; k < N; k++) begin
        if (NUM_SCALAR_BITS'(k) == num_dispatched) begin
          reason_d.regs   = ~dest_ok[k];
          reason_d.branch = ~br_ok[k];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (restore_valid && HAS_RECOVER) begin
          state_d = RECOVER;
          cnt_d   = RELOAD;
        end
      end
      RECOVER: begin
        if (restore_valid) begin
          cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign stall_cnt_d = (dispatch_stall && (stall_cnt_q != '1))
                       ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      reason_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reason_q    <= reason_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign recovering   = (state_q == RECOVER);
  assign stall_reason = reason_q;
  assign stall_cycles = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_throttle.sv
`default_nettype none
// ============================================================================
// tb_dispatch_throttle : directed self-checking bench (RECOVER_CYCLES = 2).
// ============================================================================
module tb_dispatch_throttle;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  instructions_valid = '0;
  logic [2:0]  inst_has_dest = '0;
  logic [2:0]  inst_is_branch = '0;
  logic [1:0]  rob_spots = '0;
  logic [1:0]  rs_spots = '0;
  logic [1:0]  num_regs_available = '0;
  logic [2:0]  bs_free = '0;
  logic        restore_valid = 1'b0;
  logic [1:0]  num_dispatched;
  logic        dispatch_stall;
  logic        recovering;
  logic [4:0]  stall_reason;
  logic [15:0] stall_cycles;

  int n_chk  = 0;
  int n_pass = 0;

  dispatch_throttle #(
    .N               (3),
    .NUM_SCALAR_BITS (2),
    .B_MASK_WIDTH    (4),
    .BS_CNT_BITS     (3),
    .RECOVER_CYCLES  (2),
    .STALL_CNT_W     (16)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .instructions_valid (instructions_valid),
    .inst_has_dest      (inst_has_dest),
    .inst_is_branch     (inst_is_branch),
    .rob_spots          (rob_spots),
    .rs_spots           (rs_spots),
    .num_regs_available (num_regs_available),
    .bs_free            (bs_free),
    .restore_valid      (restore_valid),
    .num_dispatched     (num_dispatched),
    .dispatch_stall     (dispatch_stall),
    .recovering         (recovering),
    .stall_reason       (stall_reason),
    .stall_cycles       (stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] v, input logic [2:0] d, input logic [2:0] b,
                       input logic [1:0] rob, input logic [1:0] rs, input logic [1:0] regs,
                       input logic [2:0] bsf, input logic rv);
    instructions_valid = v;
    inst_has_dest      = d;
    inst_is_branch     = b;
    rob_spots          = rob;
    rs_spots           = rs;
    num_regs_available = regs;
    bs_free            = bsf;
    restore_valid      = rv;
  endtask

  initial begin
    #3 reset = 1'b1;
    @(negedge clock); @(negedge clock);
    chk("rst_recovering", 32'(recovering), 32'd0);
    chk("rst_reason", 32'(stall_reason), 32'd0);
    chk("rst_cycles", 32'(stall_cycles), 32'd0);
    chk("rst_nd", 32'(num_dispatched), 32'd0);
    reset = 1'b0;

    // all resources free, no branches
    drive(2'd3, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 3'd4, 1'b0); #1;
    chk("free_nd", 32'(num_dispatched), 32'd3);
    chk("free_stall", 32'(dispatch_stall), 32'd0);
    @(negedge clock);
    chk("free_reason", 32'(stall_reason), 32'd0);
    chk("free_cycles", 32'(stall_cycles), 32'd0);

    // ROB / RS limited
    drive(2'd3, 3'b000, 3'b000, 2'd1, 2'd2, 2'd3, 3'd4, 1'b0); #1;
    chk("rob_nd", 32'(num_dispatched), 32'd1);
    chk("rob_stall", 32'(dispatch_stall), 32'd1);
    @(negedge clock);
    chk("rob_reason", 32'(stall_reason), 32'b00001);
    chk("rob_cycles", 32'(stall_cycles), 32'd1);

    // branch-stack limited, regs exactly sufficient through slot 1
    drive(2'd3, 3'b111, 3'b011, 2'd3, 2'd3, 2'd2, 3'd1, 1'b0); #1;
    chk("br_nd", 32'(num_dispatched), 32'd1);
    chk("br_stall", 32'(dispatch_stall), 32'd1);
    @(negedge clock);
    chk("br_reason", 32'(stall_reason), 32'b01000);
    chk("br_cycles", 32'(stall_cycles), 32'd2);

    // dest bits beyond instructions_valid must not consume registers
    drive(2'd1, 3'b111, 3'b000, 2'd3, 2'd3, 2'd1, 3'd4, 1'b0); #1;
    chk("mask_nd", 32'(num_dispatched), 32'd1);
    chk("mask_stall", 32'(dispatch_stall), 32'd0);
    @(negedge clock);
    chk("mask_reason", 32'(stall_reason), 32'd0);

    // regs-limited with zero free registers
    drive(2'd2, 3'b001, 3'b000, 2'd3, 2'd3, 2'd0, 3'd4, 1'b0); #1;
    chk("regs_nd", 32'(num_dispatched), 32'd0);
    @(negedge clock);
    chk("regs_reason", 32'(stall_reason), 32'b00100);
    chk("regs_cycles", 32'(stall_cycles), 32'd3);

    // single restore pulse
    drive(2'd3, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 3'd4, 1'b1); #1;
    chk("rv_nd0", 32'(num_dispatched), 32'd0);
    chk("rv_stall0", 32'(dispatch_stall), 32'd1);
    chk("rv_rec0", 32'(recovering), 32'd0);
    @(negedge clock);
    restore_valid = 1'b0; #1;
    chk("rv_rec1", 32'(recovering), 32'd1);
    chk("rv_reason1", 32'(stall_reason), 32'b10000);
    chk("rv_nd1", 32'(num_dispatched), 32'd0);
    @(negedge clock);
    chk("rv_rec2", 32'(recovering), 32'd1);
    chk("rv_reason2", 32'(stall_reason), 32'b10000);
    chk("rv_nd2", 32'(num_dispatched), 32'd0);
    @(negedge clock);
    chk("rv_rec3", 32'(recovering), 32'd0);
    chk("rv_reason3", 32'(stall_reason), 32'b10000);
    chk("rv_nd3", 32'(num_dispatched), 32'd3);
    chk("rv_cycles3", 32'(stall_cycles), 32'd6);
    @(negedge clock);
    chk("rv_reason4", 32'(stall_reason), 32'd0);

    // second pulse during RECOVER reloads the counter
    restore_valid = 1'b1;
    @(negedge clock);
    chk("ext_rec1", 32'(recovering), 32'd1);
    @(negedge clock);
    restore_valid = 1'b0;
    chk("ext_rec2", 32'(recovering), 32'd1);
    @(negedge clock);
    chk("ext_rec3", 32'(recovering), 32'd1);
    @(negedge clock); #1;
    chk("ext_rec4", 32'(recovering), 32'd0);
    chk("ext_nd4", 32'(num_dispatched), 32'd3);

    // asynchronous reset mid-RECOVER and mid-stall
    @(negedge clock);
    restore_valid = 1'b1;
    @(negedge clock);
    restore_valid = 1'b0;
    #2;
    instructions_valid = 2'd0;
    reset = 1'b1;
    #1;
    chk("arst_rec", 32'(recovering), 32'd0);
    chk("arst_reason", 32'(stall_reason), 32'd0);
    chk("arst_cycles", 32'(stall_cycles), 32'd0);
    chk("arst_nd", 32'(num_dispatched), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("arst_rec_after", 32'(recovering), 32'd0);

    // saturation of the stall counter
    drive(2'd3, 3'b000, 3'b000, 2'd0, 2'd3, 2'd3, 3'd4, 1'b0);
    repeat (65541) @(negedge clock);
    chk("sat_cycles", 32'(stall_cycles), 32'h0000FFFF);
    chk("sat_reason", 32'(stall_reason), 32'b00001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
